// File: rtl/udma_pkg.sv
// Shared uDMA/HyperBus event definitions: the slot layout of the macro event bus
// and the per-transfer direction encoding.
package udma_pkg;

    localparam int HYP_EVT_RX      = 0;
    localparam int HYP_EVT_TX      = 1;
    localparam int HYP_EVT_RD_DONE = 2;
    localparam int HYP_EVT_WR_DONE = 3;
    localparam int HYP_EVT_PER_CH  = 4;

    typedef enum logic {
        HYP_DIR_READ  = 1'b0,
        HYP_DIR_WRITE = 1'b1
    } hyp_dir_e;

endpackage

// File: rtl/hyper_dir_queue.sv
// One channel of direction tracking: an in-order 1-bit FIFO of transfer directions,
// the occupancy count, the overflow/underflow stickies and the last popped direction.
module hyper_dir_queue
    import udma_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rx_i,
    input  logic             tx_i,
    input  logic             eot_i,
    input  logic             clr_i,
    output logic             rd_done_o,
    output logic             wr_done_o,
    output logic [CNT_W-1:0] count_o,
    output logic             ovf_o,
    output logic             unf_o
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0] mem_q, mem_d;
    logic [IDX_W-1:0] head_q, head_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             rd_done_q, rd_done_d;
    logic             wr_done_q, wr_done_d;
    hyp_dir_e         last_dir_q, last_dir_d;
    hyp_dir_e         head_dir;
    hyp_dir_e         done_dir;
    int               avail;
    int               npush;
    int               accepted;
    int               tail;

    assign head_dir = hyp_dir_e'(mem_q[head_q]);

    // The pop is resolved first so that a same-cycle push can reuse the freed slot.
    always_comb begin
        mem_d      = mem_q;
        head_d     = head_q;
        count_d    = count_q;
        ovf_d      = ovf_q;
        unf_d      = unf_q;
        last_dir_d = last_dir_q;
        rd_done_d  = 1'b0;
        wr_done_d  = 1'b0;
        done_dir   = last_dir_q;
        avail      = int'(count_q);
        npush      = int'(rx_i) + int'(tx_i);
        accepted   = 0;
        tail       = 0;

        if (clr_i) begin
            head_d     = '0;
            count_d    = '0;
            ovf_d      = 1'b0;
            unf_d      = 1'b0;
            last_dir_d = HYP_DIR_READ;
        end else begin
            if (eot_i) begin
                if (count_q != '0) begin
                    done_dir   = head_dir;
                    last_dir_d = head_dir;
                    avail      = avail - 1;
                    head_d     = (int'(head_q) + 1 == DEPTH) ? '0 : head_q + 1'b1;
                end else begin
                    unf_d = 1'b1;
                end
                rd_done_d = (done_dir == HYP_DIR_READ);
                wr_done_d = (done_dir == HYP_DIR_WRITE);
            end

            accepted = (npush < DEPTH - avail) ? npush : DEPTH - avail;
            if (npush > accepted) begin
                ovf_d = 1'b1;
            end

            // A lone push is whichever event fired; a pair is always READ then WRITE.
            tail = (int'(head_d) + avail) % DEPTH;
            if (accepted >= 1) begin
                mem_d[IDX_W'(tail)] = rx_i ? HYP_DIR_READ : HYP_DIR_WRITE;
            end
            if (accepted >= 2) begin
                mem_d[IDX_W'((tail + 1) % DEPTH)] = HYP_DIR_WRITE;
            end
            count_d = CNT_W'(avail + accepted);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q      <= '0;
            head_q     <= '0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
            unf_q      <= 1'b0;
            rd_done_q  <= 1'b0;
            wr_done_q  <= 1'b0;
            last_dir_q <= HYP_DIR_READ;
        end else begin
            mem_q      <= mem_d;
            head_q     <= head_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
            unf_q      <= unf_d;
            rd_done_q  <= rd_done_d;
            wr_done_q  <= wr_done_d;
            last_dir_q <= last_dir_d;
        end
    end

    assign rd_done_o = rd_done_q;
    assign wr_done_o = wr_done_q;
    assign count_o   = count_q;
    assign ovf_o     = ovf_q;
    assign unf_o     = unf_q;

endmodule

// File: rtl/hyper_eot_classifier.sv
// Multi-channel HyperBus end-of-transfer classifier: splits each channel's EOT into
// read-done / write-done and forwards raw RX/TX events in the legacy 4-slot layout.
module hyper_eot_classifier
    import udma_pkg::*;
#(
    parameter int NB_CH = 2,
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic                   sys_clk_i,
    input  logic                   rst_i,
    input  logic [NB_CH-1:0]       rx_evt_i,
    input  logic [NB_CH-1:0]       tx_evt_i,
    input  logic [NB_CH-1:0]       eot_i,
    input  logic [NB_CH-1:0]       clr_i,
    output logic [4*NB_CH-1:0]     evt_o,
    output logic [NB_CH*CNT_W-1:0] count_o,
    output logic [NB_CH-1:0]       ovf_o,
    output logic [NB_CH-1:0]       unf_o
);

    logic [NB_CH-1:0] rx_q;
    logic [NB_CH-1:0] tx_q;
    logic [NB_CH-1:0] rd_done;
    logic [NB_CH-1:0] wr_done;

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            rx_q <= '0;
            tx_q <= '0;
        end else begin
            rx_q <= rx_evt_i;
            tx_q <= tx_evt_i;
        end
    end

    for (genvar c = 0; c < NB_CH; c++) begin : g_ch
        hyper_dir_queue #(
            .DEPTH (DEPTH),
            .CNT_W (CNT_W)
        ) u_queue (
            .clk_i     (sys_clk_i),
            .rst_i     (rst_i),
            .rx_i      (rx_evt_i[c]),
            .tx_i      (tx_evt_i[c]),
            .eot_i     (eot_i[c]),
            .clr_i     (clr_i[c]),
            .rd_done_o (rd_done[c]),
            .wr_done_o (wr_done[c]),
            .count_o   (count_o[c*CNT_W +: CNT_W]),
            .ovf_o     (ovf_o[c]),
            .unf_o     (unf_o[c])
        );
    end

    always_comb begin
        evt_o = '0;
        for (int c = 0; c < NB_CH; c++) begin
            evt_o[HYP_EVT_PER_CH*c + HYP_EVT_RX]      = rx_q[c];
            evt_o[HYP_EVT_PER_CH*c + HYP_EVT_TX]      = tx_q[c];
            evt_o[HYP_EVT_PER_CH*c + HYP_EVT_RD_DONE] = rd_done[c];
            evt_o[HYP_EVT_PER_CH*c + HYP_EVT_WR_DONE] = wr_done[c];
        end
    end

endmodule
